// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: reset vector, redirect encodings,
// and the fetch-stage state machine encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_REL  = 2'b01,
        BR_ABS  = 2'b10,
        BR_REG  = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/if_next_pc.sv
// Combinational fetch-PC sequencing: redirect target, delay-slot aware
// pending/immediate decision, and the next fetch PC.
module if_next_pc (
    input  logic [31:0] fetch_pc,
    input  logic        pending,
    input  logic [31:0] pend_target,
    input  logic        accept,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic [31:0] br_target,
    input  logic [31:0] br_pc,
    output logic [31:0] fetch_pc_nxt,
    output logic        pending_nxt,
    output logic [31:0] pend_target_nxt
);
    import cpu_pkg::*;

    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        taken;
    logic        in_slot;
    logic        past_slot;

    always_comb begin
        target    = (br_type == BR_REL) ? (br_pc + 32'd4 + br_target) : br_target;
        taken     = br_valid && (br_type != BR_NONE);
        // Delay slot still ahead of memory vs. already accepted by it.
        in_slot   = taken && (fetch_pc == br_pc + 32'd4);
        past_slot = taken && (fetch_pc == br_pc + 32'd8);
        seq_pc    = pending ? pend_target : fetch_pc + 32'd4;

        fetch_pc_nxt    = fetch_pc;
        pending_nxt     = pending;
        pend_target_nxt = pend_target;

        if (accept) begin
            // The address going out this edge is the delay slot itself.
            fetch_pc_nxt = in_slot ? target : seq_pc;
            pending_nxt  = 1'b0;
        end else if (in_slot) begin
            pending_nxt     = 1'b1;
            pend_target_nxt = target;
        end else if (past_slot) begin
            fetch_pc_nxt = target;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding memory request, output register
// towards decode, and branch/jump redirect with one delay slot.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic [31:0] br_target,
    input  logic [31:0] br_pc
);
    import cpu_pkg::*;

    fetch_state_e state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic         pending, pending_nxt;
    logic [31:0]  pend_target, pend_target_nxt;
    logic [31:0]  req_pc;
    logic         accept;

    assign accept    = (state == S_REQ) && inst_addr_ok;
    assign inst_addr = fetch_pc;

    if_next_pc u_next_pc (
        .fetch_pc        (fetch_pc),
        .pending         (pending),
        .pend_target     (pend_target),
        .accept          (accept),
        .br_valid        (br_valid),
        .br_type         (br_type),
        .br_target       (br_target),
        .br_pc           (br_pc),
        .fetch_pc_nxt    (fetch_pc_nxt),
        .pending_nxt     (pending_nxt),
        .pend_target_nxt (pend_target_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (inst_addr_ok) state_nxt = S_WAIT;
            S_WAIT:  if (inst_data_ok) state_nxt = S_HOLD;
            S_HOLD:  if (id_valid && id_ready) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            pending  <= 1'b0;
            inst_req <= 1'b0;
            id_valid <= 1'b0;
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pending  <= pending_nxt;
            inst_req <= (state_nxt == S_REQ);
            if ((state == S_WAIT) && inst_data_ok) begin
                id_valid <= 1'b1;
                id_pc    <= req_pc;
                id_inst  <= inst_rdata;
            end else if ((state == S_HOLD) && id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

    // Qualified by pending / state, so these need no reset.
    always_ff @(posedge clk) begin
        pend_target <= pend_target_nxt;
        if (accept) req_pc <= fetch_pc;
    end

endmodule
